wb_sram_bytesel: RTL

//   Parametrised Wishbone classic slave data RAM for the CPU data bus; successor to the fixed 16-word RAM.

---
 rtl/wb_sram_bytesel_if.sv | 28 ++
 rtl/wb_sram_bytesel.sv | 123 ++++++++++++
 2 files changed

// File: rtl/wb_sram_bytesel_if.sv
// Wishbone classic bus bundle for the byte-selectable data RAM.
// The master drives the request; the slave returns data and the termination pulses.
interface wb_sram_bytesel_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_i;
  logic          wb_we_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_sram_bytesel.sv
// Wishbone classic slave data RAM with byte-lane writes, programmable wait states,
// out-of-range error termination and cycle abort.
module wb_sram_bytesel #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int WS    = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  wb_sram_bytesel_if.slave    bus
);

  localparam int SW  = DW / 8;
  localparam int LSB = (SW > 1) ? $clog2(SW) : 0;
  localparam int IXW = AW - LSB;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]   CNT_INIT = (WS > 0) ? 4'(WS - 1) : 4'd0;
  localparam logic [IXW:0] DEPTH_X  = (IXW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            latch_en;

  logic [IXW-1:0]  idx_p0;
  logic [DW-1:0]   dat_p0;
  logic [SW-1:0]   sel_p0;
  logic            we_p0;

  logic            in_range;
  logic [MW-1:0]   mem_idx;
  logic            mem_wr;

  logic            ack_q, err_q;
  logic [DW-1:0]   rdat_q;

  logic [DW-1:0]   mem [DEPTH];

  // Full-width compare so indices past DEPTH never alias onto real words.
  assign in_range = ({1'b0, idx_p0} < DEPTH_X);
  assign mem_idx  = idx_p0[MW-1:0];
  assign mem_wr   = (state_q == TERM) && in_range && we_p0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          latch_en = 1'b1;
          if (WS > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = TERM;
          end
        end
      end
      WAIT: begin
        if (!(bus.wb_cyc_i && bus.wb_stb_i)) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = TERM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // TERM is the access cycle; its closing edge registers the termination.
      ack_q   <= (state_q == TERM) && in_range;
      err_q   <= (state_q == TERM) && !in_range;
      if (state_q == TERM) begin
        if (!in_range) begin
          rdat_q <= '0;
        end else if (!we_p0) begin
          rdat_q <= mem[mem_idx];
        end
      end
    end
  end

  // Request stage: captured once in IDLE, frozen while waiting.
  always_ff @(posedge wb_clk_i) begin
    if (latch_en) begin
      idx_p0 <= bus.wb_adr_i[AW-1:LSB];
      dat_p0 <= bus.wb_dat_i;
      sel_p0 <= bus.wb_sel_i;
      we_p0  <= bus.wb_we_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_wr) begin
      for (int n = 0; n < SW; n++) begin
        if (sel_p0[n]) begin
          mem[mem_idx][8*n +: 8] <= dat_p0[8*n +: 8];
        end
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_dat_o = rdat_q;

endmodule
